// File: rtl/tri_cmd_queue_if.sv
// Avalon-MM register bus and shader issue handshake for tri_cmd_queue.
// The slave modport is the queue's view; the master modport is the CPU/shader side.
interface tri_cmd_queue_if #(
    parameter int COORD_W = 16
);
    logic               chipselect;
    logic               write;
    logic               read;
    logic [7:0]         address;
    logic [COORD_W-1:0] writedata;
    logic [COORD_W-1:0] readdata;
    logic               irq;

    logic [COORD_W-1:0] v1x;
    logic [COORD_W-1:0] v1y;
    logic [COORD_W-1:0] v2x;
    logic [COORD_W-1:0] v2y;
    logic [COORD_W-1:0] v3x;
    logic [COORD_W-1:0] v3y;
    logic [COORD_W-1:0] color;
    logic               start;
    logic               done;

    modport slave (
        input  chipselect, write, read, address, writedata, done,
        output readdata, irq, v1x, v1y, v2x, v2y, v3x, v3y, color, start
    );

    modport master (
        output chipselect, write, read, address, writedata, done,
        input  readdata, irq, v1x, v1y, v2x, v2y, v3x, v3y, color, start
    );
endinterface

// File: rtl/tri_cmd_queue.sv
// Triangle command queue: CPU stages vertices over Avalon, commits them into a FIFO,
// and an issue FSM hands one triangle at a time to the shader via start/done.
module tri_cmd_queue #(
    parameter int COORD_W = 16,
    parameter int DEPTH   = 4
) (
    input  logic           clk,
    input  logic           reset,
    tri_cmd_queue_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic [COORD_W-1:0] v1x;
        logic [COORD_W-1:0] v1y;
        logic [COORD_W-1:0] v2x;
        logic [COORD_W-1:0] v2y;
        logic [COORD_W-1:0] v3x;
        logic [COORD_W-1:0] v3y;
        logic [COORD_W-1:0] color;
    } tri_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [COORD_W-1:0] stage_q [7];
    tri_t               mem [DEPTH];
    tri_t               out_q;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               overflow;
    logic               irq_en;
    logic               irq_pend;
    logic [COORD_W-1:0] readdata_q;
    logic [COORD_W-1:0] rd_mux;
    logic [COORD_W-1:0] status;

    logic wr_en;
    logic rd_en;
    logic commit;
    logic ctrl_wr;
    logic flush;
    logic ovf_clr;
    logic irq_clr;
    logic pop;
    logic start;
    logic push_ok;
    logic push_drop;
    logic run_exit;
    logic irq_set;

    // Register decode; reset priority in the sequential blocks makes accesses during reset no-ops.
    assign wr_en     = bus.chipselect && bus.write;
    assign rd_en     = bus.chipselect && bus.read;
    assign commit    = wr_en && (bus.address == 8'd6);
    assign ctrl_wr   = wr_en && (bus.address == 8'd7);
    assign flush     = ctrl_wr && bus.writedata[2];
    assign ovf_clr   = ctrl_wr && bus.writedata[0];
    assign irq_clr   = ctrl_wr && bus.writedata[3];

    // A full FIFO still takes a commit when the LOAD pop frees a slot on the same edge.
    assign push_ok   = commit && ((count < DEPTH_C) || pop);
    assign push_drop = commit && !push_ok;
    assign run_exit  = (state_q == RUN) && bus.done;
    assign irq_set   = run_exit && (count == '0) && !push_ok;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        start   = 1'b0;
        case (state_q)
            IDLE: if ((count != '0) && !flush) state_d = LOAD;
            LOAD: begin
                pop     = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                start = 1'b1;
                if (bus.done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the triangle store is plain RAM with no reset; an entry is only read after a commit wrote it.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wr_ptr] <= {stage_q[0], stage_q[1], stage_q[2], stage_q[3],
                            stage_q[4], stage_q[5], bus.writedata};
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 7; i++) stage_q[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            irq_en     <= 1'b0;
            irq_pend   <= 1'b0;
            readdata_q <= '0;
            out_q      <= '0;
        end else begin
            if (wr_en && (bus.address < 8'd7)) stage_q[bus.address[2:0]] <= bus.writedata;

            if (push_ok) wr_ptr <= wr_ptr + 1'b1;

            // Flush empties the queue by catching the read pointer up; the in-flight triangle is untouched.
            if (flush)    rd_ptr <= wr_ptr;
            else if (pop) rd_ptr <= rd_ptr + 1'b1;

            if (flush)                 count <= '0;
            else if (push_ok && !pop)  count <= count + 1'b1;
            else if (pop && !push_ok)  count <= count - 1'b1;

            if (pop) out_q <= mem[rd_ptr];

            if (ovf_clr)        overflow <= 1'b0;
            else if (push_drop) overflow <= 1'b1;

            if (ctrl_wr) irq_en <= bus.writedata[1];

            // Clearing wins over a completion that would set it on the same edge.
            if (irq_clr)      irq_pend <= 1'b0;
            else if (irq_set) irq_pend <= 1'b1;

            if (rd_en) readdata_q <= rd_mux;
        end
    end

    always_comb begin
        status      = '0;
        status[0]   = (count == '0);
        status[1]   = (count == DEPTH_C);
        status[2]   = (state_q != IDLE);
        status[3]   = overflow;
        status[4]   = irq_pend;
        status[9:5] = count;

        rd_mux = '0;
        if (bus.address < 8'd7)       rd_mux    = stage_q[bus.address[2:0]];
        else if (bus.address == 8'd7) rd_mux[1] = irq_en;
        else if (bus.address == 8'd8) rd_mux    = status;
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = irq_pend && irq_en;
    assign bus.start    = start;
    assign bus.v1x      = out_q.v1x;
    assign bus.v1y      = out_q.v1y;
    assign bus.v2x      = out_q.v2x;
    assign bus.v2y      = out_q.v2y;
    assign bus.v3x      = out_q.v3x;
    assign bus.v3y      = out_q.v3y;
    assign bus.color    = out_q.color;
endmodule

// File: tb/tb_tri_cmd_queue.sv
// Bench for tri_cmd_queue: directed scenarios with literal expectations, then random
// traffic, all checked each cycle against a queue-based reference model.
module tb_tri_cmd_queue;
    localparam int W     = 16;
    localparam int DEPTH = 4;

    typedef logic [6:0][W-1:0] tri_t;
    typedef enum int {P_IDLE, P_LOAD, P_RUN} phase_e;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    tri_cmd_queue_if #(.COORD_W(W)) bus ();

    tri_cmd_queue #(.COORD_W(W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs as the DUT saw them at the last rising edge.
    logic         smp_reset = 1'b1;
    logic         smp_cs    = 1'b0;
    logic         smp_wr    = 1'b0;
    logic         smp_rd    = 1'b0;
    logic         smp_done  = 1'b0;
    logic [7:0]   smp_addr  = '0;
    logic [W-1:0] smp_wdata = '0;

    always @(posedge clk) begin
        smp_reset <= reset;
        smp_cs    <= bus.chipselect;
        smp_wr    <= bus.write;
        smp_rd    <= bus.read;
        smp_done  <= bus.done;
        smp_addr  <= bus.address;
        smp_wdata <= bus.writedata;
    end

    // Reference model state.
    logic [W-1:0] m_stage [7];
    tri_t         q [$];
    tri_t         m_out;
    phase_e       m_phase;
    logic         m_ovf;
    logic         m_irq_en;
    logic         m_irq_pend;
    logic [W-1:0] m_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_read(input logic [7:0] a);
        logic [W-1:0] s;
        s = '0;
        if (a <= 8'd6) begin
            s = m_stage[a[2:0]];
        end else if (a == 8'd7) begin
            s[1] = m_irq_en;
        end else if (a == 8'd8) begin
            s[0]   = (q.size() == 0);
            s[1]   = (q.size() == DEPTH);
            s[2]   = (m_phase != P_IDLE);
            s[3]   = m_ovf;
            s[4]   = m_irq_pend;
            s[9:5] = 5'(q.size());
        end
        return s;
    endfunction

    task automatic model_step();
        logic   wr;
        logic   commit;
        logic   ctrl;
        logic   flush;
        logic   popping;
        logic   accepted;
        logic   exiting;
        phase_e nxt;
        tri_t   t;
        if (smp_reset) begin
            for (int i = 0; i < 7; i++) m_stage[i] = '0;
            q.delete();
            m_out      = '0;
            m_phase    = P_IDLE;
            m_ovf      = 1'b0;
            m_irq_en   = 1'b0;
            m_irq_pend = 1'b0;
            m_rdata    = '0;
            return;
        end
        wr       = smp_cs && smp_wr;
        commit   = wr && (smp_addr == 8'd6);
        ctrl     = wr && (smp_addr == 8'd7);
        flush    = ctrl && smp_wdata[2];
        popping  = (m_phase == P_LOAD);
        accepted = commit && ((q.size() < DEPTH) || popping);
        exiting  = (m_phase == P_RUN) && smp_done;

        if (smp_cs && smp_rd) m_rdata = model_read(smp_addr);

        if (ctrl && smp_wdata[3])                           m_irq_pend = 1'b0;
        else if (exiting && (q.size() == 0) && !accepted)   m_irq_pend = 1'b1;
        if (ctrl && smp_wdata[0])       m_ovf = 1'b0;
        else if (commit && !accepted)   m_ovf = 1'b1;
        if (ctrl) m_irq_en = smp_wdata[1];

        nxt = m_phase;
        case (m_phase)
            P_IDLE:  if ((q.size() > 0) && !flush) nxt = P_LOAD;
            P_LOAD:  nxt = P_RUN;
            default: if (smp_done) nxt = P_IDLE;
        endcase
        m_phase = nxt;

        if (popping && (q.size() > 0)) m_out = q.pop_front();
        if (flush) q.delete();
        if (accepted) begin
            for (int i = 0; i < 6; i++) t[i] = m_stage[i];
            t[6] = smp_wdata;
            q.push_back(t);
        end
        if (wr && (smp_addr <= 8'd6)) m_stage[smp_addr[2:0]] = smp_wdata;
    endtask

    task automatic compare();
        check("start",    32'(bus.start),    32'(m_phase == P_RUN));
        check("v1x",      32'(bus.v1x),      32'(m_out[0]));
        check("v1y",      32'(bus.v1y),      32'(m_out[1]));
        check("v2x",      32'(bus.v2x),      32'(m_out[2]));
        check("v2y",      32'(bus.v2y),      32'(m_out[3]));
        check("v3x",      32'(bus.v3x),      32'(m_out[4]));
        check("v3y",      32'(bus.v3y),      32'(m_out[5]));
        check("color",    32'(bus.color),    32'(m_out[6]));
        check("irq",      32'(bus.irq),      32'(m_irq_pend && m_irq_en));
        check("readdata", 32'(bus.readdata), 32'(m_rdata));
    endtask

    // Compare process: outputs are sampled on the falling edge, half a cycle after they settle.
    initial begin
        forever begin
            @(negedge clk);
            model_step();
            compare();
        end
    end

    task automatic idle_bus();
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;
        bus.done       = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [W-1:0] d);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = a;
        bus.writedata  = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic rd_reg(input logic [7:0] a);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = a;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
    endtask

    task automatic pulse_done();
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic status_is(input string name, input logic [W-1:0] exp);
        rd_reg(8'd8);
        check(name, 32'(bus.readdata), 32'(exp));
    endtask

    logic [W-1:0] vals [7];
    int           done_mod;

    initial begin
        vals[0] = 16'h0904; vals[1] = 16'h0904; vals[2] = 16'h19ce; vals[3] = 16'h0f9c;
        vals[4] = 16'h06e9; vals[5] = 16'h238f; vals[6] = 16'hf800;
        reset = 1'b1;
        idle_bus();
        tick(2);
        reset = 1'b0;

        // Single triangle through the issue path.
        status_is("reset_status", 16'h0001);
        check("reset_start", 32'(bus.start), 32'h0);
        for (int i = 0; i < 7; i++) wr_reg(8'(i), vals[i]);
        check("commit_no_start", 32'(bus.start), 32'h0);
        tick(1);
        check("load_no_start", 32'(bus.start), 32'h0);
        tick(1);
        check("run_start",  32'(bus.start), 32'h1);
        check("run_v1x",    32'(bus.v1x),   32'h0904);
        check("run_v2x",    32'(bus.v2x),   32'h19ce);
        check("run_v3y",    32'(bus.v3y),   32'h238f);
        check("run_color",  32'(bus.color), 32'hf800);
        pulse_done();
        check("done_start", 32'(bus.start), 32'h0);
        status_is("drained_status", 16'h0011);
        check("color_held", 32'(bus.color), 32'hf800);

        // Fill with the shader stalled, then overflow.
        do_reset();
        wr_reg(8'd0, 16'h0aaa);
        for (int i = 0; i < 5; i++) wr_reg(8'd6, W'(16'h0100 + i));
        status_is("full_status", 16'h0086);
        wr_reg(8'd6, 16'h0105);
        status_is("overflow_status", 16'h008e);
        rd_reg(8'd0);
        check("staging_kept", 32'(bus.readdata), 32'h0aaa);

        // Commit while full on the same edge as the LOAD pop.
        wr_reg(8'd7, 16'h0001);
        status_is("ovf_cleared", 16'h0086);
        pulse_done();
        tick(1);
        wr_reg(8'd6, 16'h0106);
        status_is("full_pop_push", 16'h0086);
        check("next_color", 32'(bus.color), 32'h0101);

        // Flush with three queued while a triangle runs.
        do_reset();
        for (int i = 0; i < 4; i++) wr_reg(8'd6, W'(16'h0200 + i));
        status_is("three_queued", 16'h0064);
        wr_reg(8'd7, 16'h0004);
        status_is("flushed", 16'h0005);
        check("flush_start", 32'(bus.start), 32'h1);
        pulse_done();
        status_is("flush_drained", 16'h0011);

        // Reset in the middle of RUN, with done asserted during reset.
        do_reset();
        wr_reg(8'd6, 16'h1234);
        tick(2);
        check("pre_reset_start", 32'(bus.start), 32'h1);
        bus.done = 1'b1;
        do_reset();
        bus.done = 1'b0;
        check("reset_mid_run", 32'(bus.start), 32'h0);
        check("reset_color",   32'(bus.color), 32'h0);
        status_is("post_reset_status", 16'h0001);
        pulse_done();
        status_is("done_ignored", 16'h0001);

        // Interrupt enable, drain, clear, and read latency.
        wr_reg(8'd7, 16'h0002);
        rd_reg(8'd7);
        check("irq_en_read", 32'(bus.readdata), 32'h0002);
        wr_reg(8'd6, 16'h0055);
        tick(2);
        pulse_done();
        check("irq_raised", 32'(bus.irq), 32'h1);
        wr_reg(8'd7, 16'h000a);
        check("irq_cleared", 32'(bus.irq), 32'h0);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = 8'd8;
        check("read_not_early", 32'(bus.readdata), 32'h0002);
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        check("read_latency", 32'(bus.readdata), 32'h0001);
        tick(1);
        check("read_held", 32'(bus.readdata), 32'h0001);

        // Random traffic; the shader is fast in the first half and slow in the second.
        for (int c = 0; c < 2000; c++) begin
            int k;
            done_mod = (c < 1000) ? 3 : 12;
            bus.chipselect = ($urandom_range(0, 9) < 7);
            bus.write      = $urandom_range(0, 1) == 1;
            bus.read       = $urandom_range(0, 1) == 1;
            k = int'($urandom_range(0, 15));
            if (k < 5)       bus.address = 8'd6;
            else if (k < 13) bus.address = 8'(k - 5);
            else if (k < 15) bus.address = 8'd8;
            else             bus.address = 8'($urandom);
            bus.writedata  = W'($urandom);
            if (bus.address == 8'd7 && $urandom_range(0, 3) != 0) bus.writedata[2] = 1'b0;
            bus.done       = ($urandom_range(0, done_mod - 1) == 0);
            reset          = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        idle_bus();
        reset = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tri_cmd_queue.md
TRI_CMD_QUEUE -- requirements
Module: tri_cmd_queue

Interface
REQ-001 SHALL have parameter COORD_W, default 16: width of each vertex coordinate, colour and Avalon data word.
REQ-002 SHALL have parameter DEPTH, default 4: triangle FIFO entries; power of two, 2..16.
REQ-003 SHALL have port clk, input, 1: clock; all logic rising-edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port chipselect, input, 1: Avalon slave select.
REQ-006 SHALL have port write, input, 1: Avalon write strobe.
REQ-007 SHALL have port read, input, 1: Avalon read strobe.
REQ-008 SHALL have port address, input, 8: register index.
REQ-009 SHALL have port writedata, input, COORD_W: write data.
REQ-010 SHALL have port readdata, output, COORD_W: read data, registered.
REQ-011 SHALL have port irq, output, 1: queue-drained interrupt, level.
REQ-012 SHALL have ports v1x, v1y, v2x, v2y, v3x, v3y, color, output, COORD_W each: triangle currently issued to the shader.
REQ-013 SHALL have port start, output, 1: shader start request.
REQ-014 SHALL have port done, input, 1: shader completion pulse.

Function
REQ-015 SHALL map writes: addr 0-5 = staging v1x, v1y, v2x, v2y, v3x, v3y; addr 6 = colour and commit; addr 7 = control; others ignored.
REQ-016 SHALL, on a commit write, push {6 staging regs, writedata} into the FIFO in the same edge; staging regs keep their values.
REQ-017 SHALL accept a push when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
REQ-018 SHALL drop a push that is not accepted, leave the FIFO unchanged and set sticky overflow.
REQ-019 SHALL interpret control bits: bit0=1 clears overflow; bit1 = irq_en (stored); bit2=1 flushes the FIFO (count to 0, in-flight triangle unaffected); bit3=1 clears irq_pend.
REQ-020 SHALL return on read, one cycle after chipselect&&read: addr 0-6 = staging/last colour; addr 7 = {irq_en at bit1}; addr 8 = status {bit0 empty, bit1 full, bit2 busy, bit3 overflow, bit4 irq_pend, bits[9:5] count}; others 0.
REQ-021 SHALL hold readdata when no read is active.
REQ-022 SHALL run issue FSM states IDLE, LOAD, RUN.
REQ-023 SHALL go IDLE->LOAD when count > 0 and no flush this cycle.
REQ-024 SHALL in LOAD pop the head entry into the v*/color outputs and go to RUN; count decrements unless a push is accepted the same cycle.
REQ-025 SHALL assert start throughout RUN and stay in RUN until done is sampled high.
REQ-026 SHALL on done in RUN deassert start at the same edge and return to IDLE; done outside RUN is ignored.
REQ-027 SHALL report busy = (state != IDLE).
REQ-028 SHALL keep v*/color outputs stable from LOAD until the next LOAD.
REQ-029 SHALL set irq_pend when RUN exits on done with count == 0 and no push accepted that cycle; irq = irq_pend && irq_en.
REQ-030 SHALL give a clear of irq_pend priority over a simultaneous set.
REQ-031 SHALL wrap FIFO read/write pointers modulo DEPTH.

Reset
REQ-032 SHALL on reset clear staging regs, FIFO pointers and count, overflow, irq_en, irq_pend, readdata, v*/color outputs to 0, start to 0 and FSM to IDLE, effective at the next edge even mid-RUN.
REQ-033 SHALL ignore done and Avalon accesses in a cycle with reset high.

Verification
REQ-034 SHALL verify: write addr0-5 = 0x904,0x904,0x19ce,0xf9c,0x6e9,0x238f, addr6 = 0xf800 -> LOAD 1 cycle later, start high with those outputs, done pulse -> start low, irq_pend=1.
REQ-035 SHALL verify: 5 commits with shader stalled (done=0, DEPTH=4) -> 1 in flight + 4 queued, status full=1, overflow=0; 6th commit -> overflow=1, count=4.
REQ-036 SHALL verify: commit while full in the same cycle as LOAD pop -> push accepted, count stays 4, no overflow.
REQ-037 SHALL verify: 3 queued, RUN active, write control bit2 -> count=0, start stays high until done, then IDLE, irq_pend=1.
REQ-038 SHALL verify: reset asserted mid-RUN -> next edge start=0, status reads 0x0001 (empty only), done afterwards ignored.
REQ-039 SHALL verify: irq_en=1, drain -> irq=1; control write bit3 -> irq=0 next cycle; read addr8 data appears exactly one cycle after read.
